// File: rtl/seq_det_pkg.sv
// Shared types for the sequence-detector controller: FSM state encoding and
// the bit-index width used by the serialiser (supports patterns up to 256 bits).
package seq_det_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN_WAIT,
        RUN_SHIFT,
        DRAIN
    } state_t;

    localparam int IDX_W = 8;

endpackage

// File: rtl/seq_det_piso.sv
// MSB-first parallel-to-serial shifter. Values are left-aligned in the W-bit
// register; len_m1 is the number of bits to send minus one.
module seq_det_piso
    import seq_det_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [W-1:0]     din,
    input  logic [IDX_W-1:0] len_m1,
    output logic             dout,
    output logic             last
);

    logic [W-1:0]     sr;
    logic [IDX_W-1:0] idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
        end else if (load) begin
            idx <= len_m1;
        end else if (shift && idx != '0) begin
            idx <= idx - IDX_W'(1);
        end
    end

    // Data register carries no reset; the controller gates dout by state.
    always_ff @(posedge clk) begin
        if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= sr << 1;
        end
    end

    assign dout = sr[W-1];
    assign last = (idx == '0);

endmodule

// File: rtl/seq_det_ctrl.sv
// Controller that loads a pattern into a serial sequence detector, streams bytes
// to it and counts matches. Define SEQ_DET_CTRL_IRQ_EN for a sticky match irq.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             stop,
    input  logic             data_valid,
    input  logic [7:0]       data,
    output logic             data_ready,
    output logic             det_load,
    output logic             det_din,
    input  logic             det_dout,
    output logic             busy,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_cnt,
    output logic             irq,
    input  logic             irq_clr
);

    localparam int W = (PAT_W > 8) ? PAT_W : 8;

    state_t           state, state_nxt;
    logic             stop_pend;
    logic             xfer;
    logic             hit;
    logic             load_pat;
    logic             piso_load;
    logic             piso_shift;
    logic             piso_dout;
    logic             piso_last;
    logic [W-1:0]     piso_din;
    logic [IDX_W-1:0] piso_len;

    assign xfer       = data_valid && data_ready;
    assign load_pat   = (state == IDLE) && start;
    assign piso_load  = load_pat || xfer;
    assign piso_shift = (state == LOAD) || (state == RUN_SHIFT);
    assign piso_din   = load_pat ? (W'(cfg_pattern) << (W - PAT_W)) : (W'(data) << (W - 8));
    assign piso_len   = load_pat ? IDX_W'(PAT_W - 1) : IDX_W'(7);
    // The detector answers one cycle late, so DRAIN still samples its output.
    assign hit        = det_dout && ((state == RUN_SHIFT) || (state == DRAIN));

    seq_det_piso #(
        .W (W)
    ) u_piso (
        .clk    (clk),
        .rst    (rst),
        .load   (piso_load),
        .shift  (piso_shift),
        .din    (piso_din),
        .len_m1 (piso_len),
        .dout   (piso_dout),
        .last   (piso_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (start) state_nxt = LOAD;
            LOAD:      if (piso_last) state_nxt = RUN_WAIT;
            RUN_WAIT: begin
                if (xfer) begin
                    state_nxt = RUN_SHIFT;
                end else if (stop) begin
                    state_nxt = DRAIN;
                end
            end
            RUN_SHIFT: begin
                if (piso_last && !xfer) begin
                    state_nxt = (stop_pend || stop) ? DRAIN : RUN_WAIT;
                end
            end
            DRAIN:     state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // A pending stop closes the bit-0 acceptance window so no new byte starts.
    always_comb begin
        busy       = (state != IDLE);
        det_load   = 1'b0;
        det_din    = 1'b0;
        data_ready = 1'b0;
        case (state)
            LOAD: begin
                det_load = 1'b1;
                det_din  = piso_dout;
            end
            RUN_WAIT:  data_ready = 1'b1;
            RUN_SHIFT: begin
                det_din    = piso_dout;
                data_ready = piso_last && !stop_pend && !stop;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stop_pend <= 1'b0;
        end else if ((state == RUN_WAIT) || (state == RUN_SHIFT)) begin
            if (stop) stop_pend <= 1'b1;
        end else begin
            stop_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_pulse <= 1'b0;
            match_cnt   <= '0;
        end else begin
            match_pulse <= hit;
            if (load_pat) begin
                match_cnt <= '0;
            end else if (hit && (match_cnt != '1)) begin
                match_cnt <= match_cnt + CNT_W'(1);
            end
        end
    end

`ifdef SEQ_DET_CTRL_IRQ_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq <= 1'b0;
        end else if (hit) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end
`else
    logic irq_clr_unused;
    assign irq_clr_unused = irq_clr;
    assign irq            = 1'b0;
`endif

endmodule
